// File: rtl/st7735_panel_rx_pkg.sv
// Shared opcodes, decoder state encoding and reference colours for the
// ST7735 panel receiver.
package st7735_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CASET = 3'd1,
        S_RASET = 3'd2,
        S_RAMWR = 3'd3,
        S_SKIP  = 3'd4
    } state_t;

    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

endpackage

// File: rtl/st7735_panel_rx_if.sv
// TFT pin bundle plus the decoded byte/pixel stream. The master side is
// whatever drives the panel pins; the slave side is the receiver.
interface st7735_panel_rx_if;
    logic        spi_sck;
    logic        spi_mosi;
    logic        tft_cs;
    logic        tft_dc;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic [7:0]  last_cmd;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_done;

    modport master (
        output spi_sck, spi_mosi, tft_cs, tft_dc,
        input  byte_valid, byte_data, byte_is_data, last_cmd,
        input  pix_valid, pix_x, pix_y, pix_data, frame_done
    );

    modport slave (
        input  spi_sck, spi_mosi, tft_cs, tft_dc,
        output byte_valid, byte_data, byte_is_data, last_cmd,
        output pix_valid, pix_x, pix_y, pix_data, frame_done
    );
endinterface

// File: rtl/st7735_panel_rx_spi_mode0_rx.sv
// Mode 0 SPI byte receiver running entirely in the clk domain. The pins are
// synchronised, SCK rising edges are detected and registered together with
// the MOSI/DC values seen at that edge, then shifted in one cycle later.
// Because the registered edge is consumed before the CS clear is applied, an
// 8th edge that coincides with CS rising still completes its byte.
module spi_mode0_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    input  logic       dc_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_is_data_o
);

    // {sck, mosi, cs, dc} per stage
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic       sck_s, mosi_s, cs_s, dc_s;
    logic       sck_prev_q;
    logic       edge_q, bit_q, dc_edge_q;
    logic [2:0] cnt_q;
    logic [7:0] shift_q;
    logic       dc_last_q;
    logic       done_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       byte_is_data_q;

    assign {sck_s, mosi_s, cs_s, dc_s} = sync_q[SYNC_STAGES-1];

    // Pin synchronisers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {sck_i, mosi_i, cs_i, dc_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Edge detect, shift register, bit counter and byte output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q     <= 1'b0;
            edge_q         <= 1'b0;
            bit_q          <= 1'b0;
            dc_edge_q      <= 1'b0;
            cnt_q          <= 3'd0;
            shift_q        <= 8'h00;
            dc_last_q      <= 1'b0;
            done_q         <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= 8'h00;
            byte_is_data_q <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            edge_q     <= sck_s & ~sck_prev_q & ~cs_s;
            bit_q      <= mosi_s;
            dc_edge_q  <= dc_s;

            done_q <= 1'b0;
            if (edge_q) begin
                shift_q   <= {shift_q[6:0], bit_q};
                cnt_q     <= cnt_q + 3'd1;
                dc_last_q <= dc_edge_q;
                done_q    <= (cnt_q == 3'd7);
            end else if (cs_s) begin
                cnt_q <= 3'd0;
            end

            byte_valid_q <= done_q;
            if (done_q) begin
                byte_data_q    <= shift_q;
                byte_is_data_q <= dc_last_q;
            end
        end
    end

    assign byte_valid_o   = byte_valid_q;
    assign byte_data_o    = byte_data_q;
    assign byte_is_data_o = byte_is_data_q;

endmodule

// File: rtl/st7735_panel_rx.sv
// ST7735 panel-side receiver: command/data decoder, CASET/RASET window and
// RAMWR write pointer producing addressed RGB565 pixel writes.
//
//   state   | meaning
//   S_IDLE  | no command in progress, data bytes ignored
//   S_CASET | collecting 4 column-window parameter bytes
//   S_RASET | collecting 4 row-window parameter bytes
//   S_RAMWR | streaming pixel bytes, high byte first
//   S_SKIP  | unsupported command, parameters ignored
module st7735_panel_rx
    import st7735_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 160,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    st7735_panel_rx_if.slave tft
);

    localparam logic [7:0] XE_RST = 8'(WIDTH - 1);
    localparam logic [7:0] YE_RST = 8'(HEIGHT - 1);

    logic       bv;
    logic [7:0] bd;
    logic       bisd;

    spi_mode0_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .sck_i         (tft.spi_sck),
        .mosi_i        (tft.spi_mosi),
        .cs_i          (tft.tft_cs),
        .dc_i          (tft.tft_dc),
        .byte_valid_o  (bv),
        .byte_data_o   (bd),
        .byte_is_data_o(bisd)
    );

    state_t      state_q, state_d;
    logic [1:0]  pcnt_q, pcnt_d;
    logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        half_q, half_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic        pix_valid_q, pix_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;

    // Decoder state, window, pointer and pixel output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pcnt_q       <= 2'd0;
            xs_q         <= 8'h00;
            xe_q         <= XE_RST;
            ys_q         <= 8'h00;
            ye_q         <= YE_RST;
            x_q          <= 8'h00;
            y_q          <= 8'h00;
            half_q       <= 1'b0;
            hi_q         <= 8'h00;
            last_cmd_q   <= 8'h00;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_x_q      <= 8'h00;
            pix_y_q      <= 8'h00;
            pix_data_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            half_q       <= half_d;
            hi_q         <= hi_d;
            last_cmd_q   <= last_cmd_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
        end
    end

    // Byte decode: commands in any state, data bytes by state
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        half_d       = half_q;
        hi_d         = hi_q;
        last_cmd_d   = last_cmd_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;

        if (bv && !bisd) begin
            last_cmd_d = bd;
            half_d     = 1'b0;
            case (bd)
                CMD_CASET: begin
                    state_d = S_CASET;
                    pcnt_d  = 2'd0;
                end
                CMD_RASET: begin
                    state_d = S_RASET;
                    pcnt_d  = 2'd0;
                end
                CMD_RAMWR: begin
                    state_d = S_RAMWR;
                    x_d     = xs_q;
                    y_d     = ys_q;
                end
                CMD_SWRESET: begin
                    state_d = S_IDLE;
                    xs_d    = 8'h00;
                    xe_d    = XE_RST;
                    ys_d    = 8'h00;
                    ye_d    = YE_RST;
                end
                default: state_d = S_SKIP;
            endcase
        end else if (bv) begin
            case (state_q)
                S_CASET: begin
                    // high parameter bytes are ignored: coordinates are 8-bit
                    if (pcnt_q == 2'd1) xs_d = bd;
                    if (pcnt_q == 2'd3) begin
                        xe_d    = bd;
                        state_d = S_IDLE;
                    end
                    pcnt_d = pcnt_q + 2'd1;
                end
                S_RASET: begin
                    if (pcnt_q == 2'd1) ys_d = bd;
                    if (pcnt_q == 2'd3) begin
                        ye_d    = bd;
                        state_d = S_IDLE;
                    end
                    pcnt_d = pcnt_q + 2'd1;
                end
                S_RAMWR: begin
                    if (!half_q) begin
                        hi_d   = bd;
                        half_d = 1'b1;
                    end else begin
                        half_d       = 1'b0;
                        pix_valid_d  = 1'b1;
                        pix_data_d   = {hi_q, bd};
                        pix_x_d      = x_q;
                        pix_y_d      = y_q;
                        frame_done_d = (x_q == xe_q) && (y_q == ye_q);
                        // XS > XE simply wraps through 255
                        if (x_q == xe_q) begin
                            x_d = xs_q;
                            y_d = (y_q == ye_q) ? ys_q : y_q + 8'd1;
                        end else begin
                            x_d = x_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tft.byte_valid   = bv;
    assign tft.byte_data    = bd;
    assign tft.byte_is_data = bisd;
    assign tft.last_cmd     = last_cmd_q;
    assign tft.pix_valid    = pix_valid_q;
    assign tft.pix_x        = pix_x_q;
    assign tft.pix_y        = pix_y_q;
    assign tft.pix_data     = pix_data_q;
    assign tft.frame_done   = frame_done_q;

endmodule
